mux16_reg: RTL and testbench
============================

Name: mux16_reg

Overview:
- 16-bit, two-input word multiplexer with a registered output.
- Selects operand x when sel=0 and operand y when sel=1. The selected word is captured on the rising clock edge.
- Used as the word-select element in datapaths built from the basic-gate library, for example ALU operand select and PC next-value select.
- Internally built from per-bit 2:1 mux cells, so the gate-level structure stays traceable.

Parameters:
- WIDTH, 16, data width of x, y, out_comb and out. The block is specified and verified at 16. Other widths must elaborate without change.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset. Clears the output register.
- en  input  1  capture enable. When 1, out loads the selected word at the clock edge. When 0, out holds its value.
- x  input  WIDTH  operand selected when sel=0.
- y  input  WIDTH  operand selected when sel=1.
- sel  input  1  select. 0 selects x, 1 selects y.
- out_comb  output  WIDTH  combinational mux result, with no latency.
- out  output  WIDTH  registered mux result.

Behaviour:
- Combinational path:
  - out_comb[i] = (x[i] AND NOT sel) OR (y[i] AND sel), for every bit i.
  - It is purely combinational: no latches, no clock involvement, and it is valid within the same delta as input changes.
- Registered path:
  - On posedge clk with rst=0 and en=1: out <= out_comb. Latency is exactly 1 clock from an input change to out.
  - On posedge clk with en=0: out holds its value.
- Reset:
  - rst=1 forces out to all zeros immediately, without waiting for a clock edge, and holds it there while rst is asserted.
  - While rst=1, clock edges and en are ignored.
  - out_comb is unaffected by rst.
  - After rst deasserts, the first rising edge with en=1 loads out_comb.
- Reset mid-operation: an assertion between clock edges discards the current value of out. No pending state survives reset.
- X/Z handling:
  - If sel is X or Z, out_comb must not silently pick an operand; the bits where x and y differ must read X in simulation.
  - Bits where x[i] equals y[i] must show that common value regardless of sel.
- Simultaneous changes of sel, x and y within one cycle: only the values present at the capturing edge matter.
- There is no handshake and no state machine. The only state is the WIDTH-bit output register.

Decomposition:
- Shared package (basic_gates_pkg):
  - constant WORD_W = 16.
  - typedef word_t as logic [WORD_W-1:0].
  - Constants SEL_X = 1'b0 and SEL_Y = 1'b1.
- Sub-module mux_bit: single-bit 2:1 mux built from not, and and or primitives.
  - Ports a, b, sel, out. out = a when sel=0, b when sel=1.
  - mux16_reg instantiates WIDTH copies of it in a generate loop.
- The output register lives in mux16_reg itself.

Test Plan:
- x=0x0000, y=0x5555, sel=0, en=1 -> out_comb=0x0000 immediately; out=0x0000 after the next edge. Then sel=1 -> out_comb=0x5555; out=0x5555 one edge later.
- x=0x9112, y=0xFFFF, sel=0 -> out_comb=0x9112 and out=0x9112 after one edge. Then sel=1 -> out_comb=0xFFFF and out=0xFFFF after one edge. Check out keeps its old value between the sel change and the edge.
- Hold: out=0x9112, then set en=0 with sel=1 and y=0xFFFF for 3 edges -> out stays 0x9112 while out_comb=0xFFFF. Then en=1 -> out=0xFFFF after one edge.
- Reset: out=0xFFFF, assert rst mid-cycle -> out=0x0000 before the next edge. Edges during rst with en=1 and out_comb=0xAAAA leave out=0x0000. Deassert rst -> first edge gives out=0xAAAA.
- Per-bit independence: x=0xAAAA, y=0x5555 -> sel=0 gives 0xAAAA, sel=1 gives 0x5555. Walking-one on x with y=0 and sel=0 selects each bit individually.
- Unknown select: sel=X, x=0xFF00, y=0xFFFF -> out_comb upper byte=0xFF, lower byte=X.

Source files
------------

// File: rtl/basic_gates_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : basic_gates_pkg
//  Description : Shared word width, word type and select encodings for the
//                basic-gate datapath library (word muxes, ALU operand select,
//                PC next-value select).
//  Contents    : WORD_W  - native datapath word width
//                word_t  - logic [WORD_W-1:0]
//                SEL_X   - select value choosing operand x
//                SEL_Y   - select value choosing operand y
//  Revision    : 1.0 - initial release
// ============================================================================
package basic_gates_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam logic SEL_X = 1'b0;
    localparam logic SEL_Y = 1'b1;

endpackage : basic_gates_pkg
`default_nettype wire

// File: rtl/mux16_reg_mux_bit.sv
`default_nettype none
// ============================================================================
//  Module      : mux_bit
//  Description : Single-bit 2:1 multiplexer built only from not/and/or gate
//                primitives so the gate-level structure stays traceable.
//  Ports       : a   (in)  - data selected when sel = 0
//                b   (in)  - data selected when sel = 1
//                sel (in)  - select
//                out (out) - a when sel = 0, b when sel = 1
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_bit (
    input  wire a,
    input  wire b,
    input  wire sel,
    output wire out
);

    wire sel_n;
    wire a_term;
    wire b_term;
    wire ab_term;

    not u_not_sel (sel_n, sel);
    and u_and_a   (a_term, a, sel_n);
    and u_and_b   (b_term, b, sel);

    // Consensus term a&b is logically redundant, but it makes an unknown
    // select resolve to the common value when a == b (both 1). With a == b == 0
    // every product is 0 anyway, so only differing bits propagate X.
    and u_and_ab  (ab_term, a, b);

    or  u_or_out  (out, a_term, b_term, ab_term);

endmodule : mux_bit
`default_nettype wire

// File: rtl/mux16_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mux16_reg
//  Description : WIDTH-bit two-input word multiplexer with a combinational
//                result and an enable-gated, asynchronously reset output
//                register. The mux itself is an array of per-bit gate cells.
//  Parameters  : WIDTH    - data width (specified and verified at 16)
//  Ports       : clk      (in)        - rising-edge clock
//                rst      (in)        - async active-high reset, clears out
//                en       (in)        - capture enable for out
//                x        (in WIDTH)  - operand chosen when sel = 0
//                y        (in WIDTH)  - operand chosen when sel = 1
//                sel      (in)        - select
//                out_comb (out WIDTH) - combinational mux result
//                out      (out WIDTH) - registered mux result
//  Revision    : 1.0 - initial release
// ============================================================================
module mux16_reg
    import basic_gates_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sel,
    output logic [WIDTH-1:0] out_comb,
    output logic [WIDTH-1:0] out
);

    wire  [WIDTH-1:0] mux_w;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    // One gate-level 2:1 cell per bit; bits are fully independent.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            mux_bit u_mux_bit (
                .a   (x[i]),
                .b   (y[i]),
                .sel (sel),
                .out (mux_w[i])
            );
        end
    endgenerate

    assign out_comb = mux_w;

    // Enable gating is expressed as a hold mux ahead of the register.
    always_comb begin
        out_d = out_q;
        if (en) begin
            out_d = mux_w;
        end
    end

    // Reset is asynchronous: asserting rst between edges clears out at once
    // and keeps it cleared for as long as rst stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule : mux16_reg
`default_nettype wire

// File: tb/tb_mux16_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux16_reg
//  Description : Directed self-checking bench for mux16_reg. Expected
//                registered values are queued when the capturing edge is
//                requested and popped/compared one edge later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux16_reg;
    import basic_gates_pkg::*;

    logic  clk;
    logic  rst;
    logic  en;
    word_t x;
    word_t y;
    logic  sel;
    word_t out_comb;
    word_t out;

    int    n_checks;
    int    n_errors;

    word_t exp_q[$];
    string tag_q[$];

    mux16_reg #(.WIDTH(WORD_W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .x        (x),
        .y        (y),
        .sel      (sel),
        .out_comb (out_comb),
        .out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_comb(input word_t exp, input string tag);
        #1;
        n_checks++;
        assert (out_comb === exp) else begin
            n_errors++;
            $error("FAIL %s: out_comb observed %h expected %h", tag, out_comb, exp);
        end
    endtask

    task automatic chk_out(input word_t exp, input string tag);
        n_checks++;
        assert (out === exp) else begin
            n_errors++;
            $error("FAIL %s: out observed %h expected %h", tag, out, exp);
        end
    endtask

    // Queue the value out must hold after the next rising edge, take the
    // edge, then pop and compare.
    task automatic step(input word_t exp, input string tag);
        word_t e;
        string t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk_out(e, t);
    endtask

    initial begin
        logic probe;
        n_checks = 0;
        n_errors = 0;

        // Reset state
        rst = 1'b1;
        en  = 1'b0;
        x   = 16'h0000;
        y   = 16'h5555;
        sel = 1'b0;
        #2;
        chk_out(16'h0000, "reset_out");
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;

        // x=0000 / y=5555
        chk_comb(16'h0000, "c0_sel0_comb");
        step(16'h0000, "c0_sel0_out");
        sel = 1'b1;
        chk_comb(16'h5555, "c0_sel1_comb");
        chk_out(16'h0000, "c0_sel1_before_edge");
        step(16'h5555, "c0_sel1_out");

        // x=9112 / y=FFFF
        x = 16'h9112; y = 16'hFFFF; sel = 1'b0;
        chk_comb(16'h9112, "c1_sel0_comb");
        chk_out(16'h5555, "c1_old_before_edge");
        step(16'h9112, "c1_sel0_out");
        sel = 1'b1;
        chk_comb(16'hFFFF, "c1_sel1_comb");
        chk_out(16'h9112, "c1_hold_until_edge");
        step(16'hFFFF, "c1_sel1_out");

        // Hold with en=0
        sel = 1'b0;
        step(16'h9112, "hold_preload");
        en = 1'b0; sel = 1'b1;
        chk_comb(16'hFFFF, "hold_comb");
        for (int i = 0; i < 3; i++) step(16'h9112, "hold_out");
        en = 1'b1;
        step(16'hFFFF, "hold_release");

        // Asynchronous reset mid-cycle
        #3;
        rst = 1'b1;
        #1;
        chk_out(16'h0000, "rst_async_clear");
        x = 16'hAAAA; y = 16'h5555; sel = 1'b0; en = 1'b1;
        chk_comb(16'hAAAA, "rst_comb_unaffected");
        step(16'h0000, "rst_edge_ignored");
        step(16'h0000, "rst_edge_ignored");
        #3;
        rst = 1'b0;
        step(16'hAAAA, "rst_release_load");

        // Per-bit independence
        sel = 1'b1;
        chk_comb(16'h5555, "alt_sel1_comb");
        step(16'h5555, "alt_sel1_out");

        // Walking one on x, y=0, sel=0
        y = 16'h0000; sel = 1'b0;
        for (int i = 0; i < 16; i++) begin
            word_t w;
            w = word_t'(1) << i;
            x = w;
            chk_comb(w, "walk1_comb");
            step(w, "walk1_out");
        end

        // Unknown select: equal bits keep their value, differing bits go X
        // (the X part is only observable on a four-state simulator).
        x = 16'hFF00; y = 16'hFFFF; sel = 1'bx;
        #1;
        n_checks++;
        assert (out_comb[15:8] === 8'hFF) else begin
            n_errors++;
            $error("FAIL selx_upper: observed %h expected ff", out_comb[15:8]);
        end
        probe = 1'bx;
        if ($isunknown(probe)) begin
            n_checks++;
            assert (out_comb[7:0] === 8'bxxxx_xxxx) else begin
                n_errors++;
                $error("FAIL selx_lower: observed %h expected xx", out_comb[7:0]);
            end
        end
        sel = 1'b0;
        chk_comb(16'hFF00, "selx_recover_comb");
        step(16'hFF00, "selx_recover_out");

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_errors++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mux16_reg
`default_nettype wire
